// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC scalar-multiplication controller.
package ecc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    DBL_REQ,
    DBL_WAIT,
    ADD_REQ,
    ADD_WAIT,
    NEXT,
    FIN
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_DBL = 1'b1;

endpackage

// File: rtl/ecc_bit_index.sv
// Scalar bit-index counter: loads n-1, counts down, and flags when it reaches zero.
module ecc_bit_index #(
  parameter int unsigned n  = 231,
  parameter int unsigned IW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic          dec_i,
  output logic [IW-1:0] idx_o,
  output logic          zero_o
);

  localparam logic [IW-1:0] TOP = IW'(n - 1);

  logic [IW-1:0] idx_q;
  logic          zero_q;

  // zero flag tracks the counter so it is available in the same cycle as idx
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q  <= '0;
      zero_q <= 1'b1;
    end else if (load_i) begin
      idx_q  <= TOP;
      zero_q <= (TOP == '0);
    end else if (dec_i) begin
      idx_q  <= idx_q - IW'(1);
      zero_q <= (idx_q == IW'(1));
    end
  end

  assign idx_o  = idx_q;
  assign zero_o = zero_q;

endmodule

// File: rtl/ecc_scalar_mult_ctrl.sv
// Left-to-right double-and-add controller for Q = k*P; sequences an external
// point add/double engine and resolves infinity and equal-x cases itself.
module ecc_scalar_mult_ctrl
  import ecc_pkg::*;
#(
  parameter int unsigned n  = 231,
  parameter int unsigned IW = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] p,
  input  logic [n-1:0] k,
  input  logic [n-1:0] px,
  input  logic [n-1:0] py,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] qx,
  output logic [n-1:0] qy,
  output logic         q_inf,
  output logic         op_start,
  output logic         op_dbl,
  output logic [n-1:0] op_x1,
  output logic [n-1:0] op_y1,
  output logic [n-1:0] op_x2,
  output logic [n-1:0] op_y2,
  input  logic         op_ready,
  input  logic [n-1:0] op_x3,
  input  logic [n-1:0] op_y3
);

  state_e state_q, state_d;

  logic [n-1:0] kr_q, kr_d, prx_q, prx_d, pry_q, pry_d;
  logic [n-1:0] rx_q, rx_d, ry_q, ry_d;
  logic         rinf_q, rinf_d;
  logic         busy_q, busy_d, done_q, done_d, q_inf_q, q_inf_d;
  logic [n-1:0] qx_q, qx_d, qy_q, qy_d;
  logic         op_start_q, op_start_d, op_dbl_q, op_dbl_d;
  logic [n-1:0] op_x1_q, op_x1_d, op_y1_q, op_y1_d, op_x2_q, op_x2_d, op_y2_q, op_y2_d;

  logic          idx_load, idx_dec, idx_zero;
  logic [IW-1:0] idx;
  logic [n-1:0]  bit_mask;
  logic          kr_bit;
  logic          res_valid;

  // the modulus is consumed by the engine; this block only needs it held stable
  logic unused_p;
  assign unused_p = ^p;

  ecc_bit_index #(.n(n), .IW(IW)) u_bit_index (
    .clk    (clk),
    .reset  (reset),
    .load_i (idx_load),
    .dec_i  (idx_dec),
    .idx_o  (idx),
    .zero_o (idx_zero)
  );

  assign bit_mask = {{(n-1){1'b0}}, 1'b1} << idx;
  assign kr_bit   = |(kr_q & bit_mask);
  // a stale op_ready can still be high in the cycle op_start is presented
  assign res_valid = op_ready && !op_start_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      kr_q       <= '0;
      prx_q      <= '0;
      pry_q      <= '0;
      rx_q       <= '0;
      ry_q       <= '0;
      rinf_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      q_inf_q    <= 1'b0;
      qx_q       <= '0;
      qy_q       <= '0;
      op_start_q <= 1'b0;
      op_dbl_q   <= 1'b0;
      op_x1_q    <= '0;
      op_y1_q    <= '0;
      op_x2_q    <= '0;
      op_y2_q    <= '0;
    end else begin
      state_q    <= state_d;
      kr_q       <= kr_d;
      prx_q      <= prx_d;
      pry_q      <= pry_d;
      rx_q       <= rx_d;
      ry_q       <= ry_d;
      rinf_q     <= rinf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      q_inf_q    <= q_inf_d;
      qx_q       <= qx_d;
      qy_q       <= qy_d;
      op_start_q <= op_start_d;
      op_dbl_q   <= op_dbl_d;
      op_x1_q    <= op_x1_d;
      op_y1_q    <= op_y1_d;
      op_x2_q    <= op_x2_d;
      op_y2_q    <= op_y2_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    kr_d       = kr_q;
    prx_d      = prx_q;
    pry_d      = pry_q;
    rx_d       = rx_q;
    ry_d       = ry_q;
    rinf_d     = rinf_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    q_inf_d    = q_inf_q;
    qx_d       = qx_q;
    qy_d       = qy_q;
    op_start_d = 1'b0;
    op_dbl_d   = op_dbl_q;
    op_x1_d    = op_x1_q;
    op_y1_d    = op_y1_q;
    op_x2_d    = op_x2_q;
    op_y2_d    = op_y2_q;
    idx_load   = 1'b0;
    idx_dec    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          kr_d     = k;
          prx_d    = px;
          pry_d    = py;
          idx_load = 1'b1;
          busy_d   = 1'b1;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        if (kr_q == '0) begin
          rinf_d  = 1'b1;
          state_d = FIN;
        end else if (kr_bit) begin
          rx_d   = prx_q;
          ry_d   = pry_q;
          rinf_d = 1'b0;
          if (idx_zero) begin
            state_d = FIN;
          end else begin
            idx_dec = 1'b1;
            state_d = DBL_REQ;
          end
        end else begin
          idx_dec = 1'b1;
        end
      end
      DBL_REQ: begin
        if (rinf_q || (ry_q == '0)) begin
          rinf_d  = 1'b1;
          state_d = kr_bit ? ADD_REQ : NEXT;
        end else begin
          op_start_d = 1'b1;
          op_dbl_d   = OP_DBL;
          op_x1_d    = rx_q;
          op_y1_d    = ry_q;
          op_x2_d    = '0;
          op_y2_d    = '0;
          state_d    = DBL_WAIT;
        end
      end
      DBL_WAIT: begin
        if (res_valid) begin
          rx_d    = op_x3;
          ry_d    = op_y3;
          state_d = kr_bit ? ADD_REQ : NEXT;
        end
      end
      ADD_REQ: begin
        if (rinf_q) begin
          rx_d    = prx_q;
          ry_d    = pry_q;
          rinf_d  = 1'b0;
          state_d = NEXT;
        end else if (rx_q == prx_q) begin
          // R == P becomes a doubling of P; R == -P or a y=0 doubling is infinity
          if ((ry_q == pry_q) && (pry_q != '0)) begin
            op_start_d = 1'b1;
            op_dbl_d   = OP_DBL;
            op_x1_d    = prx_q;
            op_y1_d    = pry_q;
            op_x2_d    = '0;
            op_y2_d    = '0;
            state_d    = ADD_WAIT;
          end else begin
            rinf_d  = 1'b1;
            state_d = NEXT;
          end
        end else begin
          op_start_d = 1'b1;
          op_dbl_d   = OP_ADD;
          op_x1_d    = rx_q;
          op_y1_d    = ry_q;
          op_x2_d    = prx_q;
          op_y2_d    = pry_q;
          state_d    = ADD_WAIT;
        end
      end
      ADD_WAIT: begin
        if (res_valid) begin
          rx_d    = op_x3;
          ry_d    = op_y3;
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (idx_zero) begin
          state_d = FIN;
        end else begin
          idx_dec = 1'b1;
          state_d = DBL_REQ;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // result and done are registered on the way into FIN so they appear in FIN
    if (state_d == FIN) begin
      done_d  = 1'b1;
      busy_d  = 1'b0;
      q_inf_d = rinf_d;
      qx_d    = rinf_d ? '0 : rx_d;
      qy_d    = rinf_d ? '0 : ry_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign qx       = qx_q;
  assign qy       = qy_q;
  assign q_inf    = q_inf_q;
  assign op_start = op_start_q;
  assign op_dbl   = op_dbl_q;
  assign op_x1    = op_x1_q;
  assign op_y1    = op_y1_q;
  assign op_x2    = op_x2_q;
  assign op_y2    = op_y2_q;

endmodule

// File: tb/tb_ecc_scalar_mult_ctrl.sv
// Scoreboarded bench for ecc_scalar_mult_ctrl on y^2 = x^3 + x + 1 over GF(23).
module tb_ecc_scalar_mult_ctrl;

  localparam int unsigned N     = 8;
  localparam int unsigned IWB   = 4;
  localparam int          P_MOD = 23;
  localparam int          ELAT  = 5;

  typedef struct {
    int x;
    int y;
    bit inf;
  } pt_t;

  typedef struct {
    bit dbl;
    int x1;
    int y1;
    int x2;
    int y2;
  } op_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] p = 8'd23;
  logic [N-1:0] k = '0, px = '0, py = '0;
  logic         busy, done, q_inf, op_start, op_dbl;
  logic [N-1:0] qx, qy, op_x1, op_y1, op_x2, op_y2;
  logic         op_ready = 1'b0;
  logic [N-1:0] op_x3 = '0, op_y3 = '0;

  int  vectors = 0;
  int  miscompares = 0;
  int  last_lat = 0;
  int  eng_cnt = 0;
  pt_t eng_res;
  pt_t exp_q[$];
  op_t ops_log[$];

  ecc_scalar_mult_ctrl #(.n(N), .IW(IWB)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .p        (p),
    .k        (k),
    .px       (px),
    .py       (py),
    .busy     (busy),
    .done     (done),
    .qx       (qx),
    .qy       (qy),
    .q_inf    (q_inf),
    .op_start (op_start),
    .op_dbl   (op_dbl),
    .op_x1    (op_x1),
    .op_y1    (op_y1),
    .op_x2    (op_x2),
    .op_y2    (op_y2),
    .op_ready (op_ready),
    .op_x3    (op_x3),
    .op_y3    (op_y3)
  );

  always #5 clk = ~clk;

  function automatic int md(input int a);
    int r;
    r = a % P_MOD;
    return (r < 0) ? r + P_MOD : r;
  endfunction

  function automatic int inv(input int a);
    int r;
    r = 1;
    for (int i = 0; i < P_MOD - 2; i++) r = md(r * a);
    return r;
  endfunction

  // Textbook affine group law, including the identity and inverse cases
  function automatic pt_t ec_add(input pt_t a, input pt_t b);
    pt_t r;
    int  lam;
    if (a.inf) return b;
    if (b.inf) return a;
    r.x = 0; r.y = 0; r.inf = 1'b1;
    if (a.x == b.x && md(a.y + b.y) == 0) return r;
    if (a.x == b.x) lam = md(md(3 * a.x * a.x + 1) * inv(md(2 * a.y)));
    else            lam = md(md(b.y - a.y) * inv(md(b.x - a.x)));
    r.x   = md(lam * lam - a.x - b.x);
    r.y   = md(lam * (a.x - r.x) - a.y);
    r.inf = 1'b0;
    return r;
  endfunction

  // k*B by k repeated additions
  function automatic pt_t ref_mult(input int kk, input pt_t b);
    pt_t acc;
    acc.x = 0; acc.y = 0; acc.inf = 1'b1;
    for (int i = 0; i < kk; i++) acc = ec_add(acc, b);
    return acc;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_op(input string nm, input int idx, input int dbl,
                        input int x1, input int y1, input int x2, input int y2);
    op_t o;
    o = ops_log[idx];
    vectors++;
    if (o.dbl != dbl || o.x1 != x1 || o.y1 != y1 || (!dbl && (o.x2 != x2 || o.y2 != y2))) begin
      miscompares++;
      $display("FAIL %s: got dbl=%0d (%0d,%0d)(%0d,%0d) expected dbl=%0d (%0d,%0d)(%0d,%0d)",
               nm, o.dbl, o.x1, o.y1, o.x2, o.y2, dbl, x1, y1, x2, y2);
    end
  endtask

  // Behavioural point engine: fixed latency, checks it is never handed an undefined case
  always @(negedge clk) begin
    if (op_start) begin
      op_t o;
      pt_t a, b;
      o.dbl = op_dbl; o.x1 = int'(op_x1); o.y1 = int'(op_y1);
      o.x2 = int'(op_x2); o.y2 = int'(op_y2);
      ops_log.push_back(o);
      vectors++;
      if (o.dbl ? (o.y1 == 0) : (o.x1 == o.x2)) begin
        miscompares++;
        $display("FAIL engine_op_legal: got dbl=%0d (%0d,%0d)(%0d,%0d) expected no y=0 double or equal-x add",
                 o.dbl, o.x1, o.y1, o.x2, o.y2);
      end
      a.x = o.x1; a.y = o.y1; a.inf = 1'b0;
      b.x = o.x2; b.y = o.y2; b.inf = 1'b0;
      eng_res  = o.dbl ? ec_add(a, a) : ec_add(a, b);
      eng_cnt  = ELAT;
      op_ready = 1'b0;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        op_x3    = N'(eng_res.x);
        op_y3    = N'(eng_res.y);
        op_ready = 1'b1;
      end
    end
  end

  // Result monitor
  always @(negedge clk) begin
    if (reset && done) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done: got done=1 expected no pending request");
      end else begin
        pt_t e;
        e = exp_q.pop_front();
        if (qx !== N'(e.x) || qy !== N'(e.y) || q_inf !== e.inf) begin
          miscompares++;
          $display("FAIL result: got (%0d,%0d,inf=%0d) expected (%0d,%0d,inf=%0d)",
                   qx, qy, q_inf, e.x, e.y, e.inf);
        end
      end
    end
  end

  task automatic run(input int kk, input pt_t b);
    int lat;
    exp_q.push_back(ref_mult(kk, b));
    ops_log.delete();
    start = 1'b1; k = N'(kk); px = N'(b.x); py = N'(b.y);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    chk("busy_after_start", int'(busy), 1);
    while (!done && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done for k=%0d", lat, kk);
      exp_q.delete();
    end
    last_lat = lat;
    @(negedge clk);
  endtask

  initial begin
    pt_t gp, b14, rb, e;
    int  w;
    gp.x = 3; gp.y = 10; gp.inf = 1'b0;
    b14 = ref_mult(14, gp);

    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_op_start", int'(op_start), 0);
    chk("reset_q", int'({q_inf, qx, qy, op_dbl, op_x1}), 0);
    reset = 1'b1;
    @(negedge clk);

    run(1, gp);
    chk("k1_engine_ops", ops_log.size(), 0);

    run(2, gp);
    chk("k2_engine_ops", ops_log.size(), 1);
    if (ops_log.size() == 1) chk_op("k2_op0", 0, 1, 3, 10, 0, 0);

    run(3, gp);
    chk("k3_engine_ops", ops_log.size(), 2);
    if (ops_log.size() == 2) begin
      chk_op("k3_op0_dbl", 0, 1, 3, 10, 0, 0);
      chk_op("k3_op1_add", 1, 0, 7, 12, 3, 10);
    end

    run(0, gp);
    chk("k0_latency", last_lat, 2);
    chk("k0_engine_ops", ops_log.size(), 0);

    run(28, gp);
    chk("k28_engine_ops", ops_log.size(), 5);

    run(3, b14);
    chk("order2_engine_ops", ops_log.size(), 0);
    run(2, b14);

    // Abort a k=3 run while the add is outstanding
    exp_q.push_back(ref_mult(3, gp));
    ops_log.delete();
    start = 1'b1; k = 8'd3; px = 8'd3; py = 8'd10;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (ops_log.size() < 2 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("abort_reached_add", ops_log.size(), 2);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    e = exp_q.pop_back();
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_op_start", int'(op_start), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run(2, gp);
    chk("post_abort_ops", ops_log.size(), 1);

    for (int i = 0; i < 25; i++) begin
      rb = ref_mult(int'($urandom_range(1, 27)), gp);
      run(int'($urandom_range(0, 255)), rb);
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
